// File: rtl/controlador_ciclo.sv
// rtl/controlador_ciclo.sv - washing-machine cycle sequencer: start, delayed-start wait, fill, wash, rinse, spin
module controlador_ciclo #(
    parameter int CW         = 8,
    parameter int T_ENCHER   = 20,
    parameter int T_LAVAR    = 40,
    parameter int T_ENXAGUAR = 30,
    parameter int T_CENTRIF  = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iniciar,
    input  logic       porta_fechada,
    input  logic       nivel_cheio,
    input  logic       pausa,
    input  logic       cancelar,
    input  logic       pronto_atraso,
    output logic       iniciar_atraso,
    output logic       valvula,
    output logic       motor,
    output logic       motor_rapido,
    output logic       trava_porta,
    output logic       fim_ciclo,
    output logic       erro,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        ESPERA      = 3'd1,
        ENCHER      = 3'd2,
        LAVAR       = 3'd3,
        ENXAGUAR    = 3'd4,
        CENTRIFUGAR = 3'd5,
        FIM         = 3'd6,
        ERRO        = 3'd7
    } state_t;

    localparam logic [CW-1:0] ULT_ENCHER   = CW'(T_ENCHER - 1);
    localparam logic [CW-1:0] ULT_LAVAR    = CW'(T_LAVAR - 1);
    localparam logic [CW-1:0] ULT_ENXAGUAR = CW'(T_ENXAGUAR - 1);
    localparam logic [CW-1:0] ULT_CENTRIF  = CW'(T_CENTRIF - 1);

    state_t        state;
    logic [CW-1:0] cont;
    logic          em_fase;

    // Timed phases are the only states that pausa can freeze.
    assign em_fase = (state == ENCHER) || (state == LAVAR) ||
                     (state == ENXAGUAR) || (state == CENTRIFUGAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OCIOSO;
            cont  <= '0;
        end else if (cancelar && (state != OCIOSO)) begin
            state <= OCIOSO;
            cont  <= '0;
        end else if (pausa && em_fase) begin
            state <= state;
            cont  <= cont;
        end else begin
            case (state)
                OCIOSO: begin
                    cont <= '0;
                    if (iniciar && porta_fechada) begin
                        state <= ESPERA;
                    end
                end
                ESPERA: begin
                    cont <= '0;
                    if (pronto_atraso) begin
                        state <= ENCHER;
                    end
                end
                ENCHER: begin
                    // A full drum takes precedence over a timeout on the same edge.
                    if (nivel_cheio) begin
                        state <= LAVAR;
                        cont  <= '0;
                    end else if (cont == ULT_ENCHER) begin
                        state <= ERRO;
                        cont  <= '0;
                    end else begin
                        cont <= cont + 1'b1;
                    end
                end
                LAVAR: begin
                    if (cont == ULT_LAVAR) begin
                        state <= ENXAGUAR;
                        cont  <= '0;
                    end else begin
                        cont <= cont + 1'b1;
                    end
                end
                ENXAGUAR: begin
                    if (cont == ULT_ENXAGUAR) begin
                        state <= CENTRIFUGAR;
                        cont  <= '0;
                    end else begin
                        cont <= cont + 1'b1;
                    end
                end
                CENTRIFUGAR: begin
                    if (cont == ULT_CENTRIF) begin
                        state <= FIM;
                        cont  <= '0;
                    end else begin
                        cont <= cont + 1'b1;
                    end
                end
                FIM: begin
                    state <= OCIOSO;
                    cont  <= '0;
                end
                ERRO: begin
                    state <= ERRO;
                    cont  <= '0;
                end
                default: begin
                    state <= OCIOSO;
                    cont  <= '0;
                end
            endcase
        end
    end

    // Actuators drop the same cycle pausa rises; the door lock does not.
    always_comb begin
        iniciar_atraso = (state == ESPERA);
        valvula        = (state == ENCHER) && !pausa;
        motor          = ((state == LAVAR) || (state == ENXAGUAR) ||
                          (state == CENTRIFUGAR)) && !pausa;
        motor_rapido   = (state == CENTRIFUGAR) && !pausa;
        trava_porta    = (state == ESPERA) || em_fase;
        fim_ciclo      = (state == FIM);
        erro           = (state == ERRO);
        estado         = state;
    end

endmodule
